// File: rtl/cla_multiword_adder.sv
// Sequential wide adder/subtractor: one N-bit carry-lookahead slice per clock,
// LSB slice first, with a registered carry chained between slices.
module cla_multiword_adder #(
    parameter int N = 8,
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           sub,
    input  logic [N*K-1:0] a,
    input  logic [N*K-1:0] b,
    input  logic           c_in,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [N*K-1:0] s,
    output logic           c_out,
    output logic           ovf
);
    localparam int W  = N * K;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nx;
    logic [W-1:0]  a_q, b_q;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          last;

    logic [N-1:0]  sa, sb, g, p, sum;
    logic [N:0]    c;
    logic          pp;

    assign last  = (cnt == CW'(K - 1));
    assign ready = (state == IDLE);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign sa = a_q[cnt*N +: N];
    assign sb = b_q[cnt*N +: N];

    // Each carry is a flat sum of products over g/p and the slice carry-in,
    // so no carry depends on the previous bit's carry.
    always_comb begin
        g  = sa & sb;
        p  = sa ^ sb;
        c  = '0;
        pp = 1'b0;
        c[0] = carry;
        for (int j = 0; j < N; j++) begin
            c[j+1] = g[j];
            pp     = p[j];
            for (int k = j - 1; k >= 0; k--) begin
                c[j+1] = c[j+1] | (pp & g[k]);
                pp     = pp & p[k];
            end
            c[j+1] = c[j+1] | (pp & carry);
        end
        sum = p ^ c[N-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_q   <= a;
                    b_q   <= sub ? ~b : b;
                    carry <= sub ? 1'b1 : c_in;
                    cnt   <= '0;
                end
                RUN: begin
                    s[cnt*N +: N] <= sum;
                    carry         <= c[N];
                    cnt           <= cnt + CW'(1);
                    if (last) begin
                        c_out <= c[N];
                        ovf   <= c[N] ^ c[N-1];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_multiword_adder.sv
// Directed bench: hand-computed vector table on N=8/K=4, multi-cycle corner
// sequences, and exhaustive sweeps of the N=1/K=2 and N=2/K=1 configurations.
module tb_cla_multiword_adder;
    localparam int K = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start, sub, c_in;
    logic [31:0] a, b;
    logic        ready, busy, done, c_out, ovf;
    logic [31:0] s;

    logic       st, ssub, sci;
    logic [1:0] xa, xb;
    logic       r1, bz1, d1, co1, ov1;
    logic [1:0] s1;
    logic       r2, bz2, d2, co2, ov2;
    logic [1:0] s2;

    cla_multiword_adder #(.N(8), .K(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .c_in(c_in),
        .ready(ready), .busy(busy), .done(done), .s(s), .c_out(c_out), .ovf(ovf));

    cla_multiword_adder #(.N(1), .K(2)) dut_n1k2 (
        .clk(clk), .rst_n(rst_n), .start(st), .sub(ssub), .a(xa), .b(xb), .c_in(sci),
        .ready(r1), .busy(bz1), .done(d1), .s(s1), .c_out(co1), .ovf(ov1));

    cla_multiword_adder #(.N(2), .K(1)) dut_n2k1 (
        .clk(clk), .rst_n(rst_n), .start(st), .sub(ssub), .a(xa), .b(xb), .c_in(sci),
        .ready(r2), .busy(bz2), .done(d2), .s(s2), .c_out(co2), .ovf(ov2));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    // returns {ovf, c_out, s}
    function automatic logic [33:0] model32(input logic sb, input logic [31:0] x,
                                            input logic [31:0] y, input logic ci);
        logic [31:0] yy;
        logic [32:0] r;
        logic        o;
        yy = sb ? ~y : y;
        r  = {1'b0, x} + {1'b0, yy} + {32'd0, (sb ? 1'b1 : ci)};
        o  = (x[31] == yy[31]) && (r[31] != x[31]);
        return {o, r};
    endfunction

    function automatic logic [3:0] model2(input logic sb, input logic [1:0] x,
                                          input logic [1:0] y, input logic ci);
        logic [1:0] yy;
        logic [2:0] r;
        logic       o;
        yy = sb ? ~y : y;
        r  = {1'b0, x} + {1'b0, yy} + {2'd0, (sb ? 1'b1 : ci)};
        o  = (x[1] == yy[1]) && (r[1] != x[1]);
        return {o, r};
    endfunction

    task automatic run_main(input logic sb, input logic [31:0] aa, input logic [31:0] bb,
                            input logic ci, output int lat);
        @(negedge clk);
        chk("ready_before_start", ready, 1);
        start = 1'b1; sub = sb; a = aa; b = bb; c_in = ci;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    typedef struct {
        logic        sb;
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [31:0] es;
        logic        ec;
        logic        eo;
    } vec_t;

    vec_t vt[8];
    int   lat;

    initial begin
        rst_n = 1'b0;
        start = 0; sub = 0; c_in = 0; a = '0; b = '0;
        st = 0; ssub = 0; sci = 0; xa = '0; xb = '0;

        vt[0] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vt[1] = '{1'b1, 32'd5,         32'd7,         1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vt[2] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vt[3] = '{1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0};
        vt[4] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vt[5] = '{1'b1, 32'd7,         32'd5,         1'b0, 32'd2,         1'b1, 1'b0};
        vt[6] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vt[7] = '{1'b1, 32'h0000_0010, 32'h0000_0010, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

        #12;
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_s", s, 0);
        chk("rst_cout_ovf", {c_out, ovf}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            run_main(vt[i].sb, vt[i].a, vt[i].b, vt[i].ci, lat);
            chk($sformatf("vec%0d_latency", i), lat, K + 1);
            chk($sformatf("vec%0d_s", i), s, vt[i].es);
            chk($sformatf("vec%0d_cout", i), c_out, vt[i].ec);
            chk($sformatf("vec%0d_ovf", i), ovf, vt[i].eo);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_done_one_cycle", i), {done, ready}, 2'b01);
            chk($sformatf("vec%0d_s_held", i), s, vt[i].es);
        end

        // Asynchronous reset in cycle 2 of an operation
        @(negedge clk);
        start = 1'b1; sub = 0; a = 32'h1111_1111; b = 32'h2222_2222; c_in = 1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready_busy_done", {ready, busy, done}, 3'b100);
        chk("midrst_s", s, 0);
        chk("midrst_cout_ovf", {c_out, ovf}, 0);
        @(negedge clk); rst_n = 1'b1;
        run_main(1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, lat);
        chk("postrst_latency", lat, K + 1);
        chk("postrst_s", s, 32'h0000_0100);
        @(posedge clk); #1;

        // Start pulses and operand changes during RUN are ignored
        begin
            int ndone = 0;
            @(negedge clk);
            start = 1'b1; sub = 0; a = 32'h0000_0005; b = 32'h0000_0007; c_in = 0;
            for (int cyc = 0; cyc < K + 6; cyc++) begin
                @(posedge clk); #1;
                if (done) begin
                    ndone++;
                    chk("ign_s", s, 32'd12);
                    chk("ign_cout_ovf", {c_out, ovf}, 0);
                end
                @(negedge clk);
                start = busy; a = $urandom; b = $urandom; sub = $urandom_range(0, 1);
            end
            start = 1'b0;
            chk("ign_done_count", ndone, 1);
        end

        // Back-to-back with start held high
        begin
            logic [33:0] q[$];
            logic [33:0] e;
            int ndone = 0;
            int prev = -1;
            for (int cyc = 0; cyc < 60 && ndone < 4; cyc++) begin
                @(negedge clk);
                start = 1'b1; a = $urandom; b = $urandom; sub = $urandom_range(0, 1);
                c_in = $urandom_range(0, 1);
                if (ready) q.push_back(model32(sub, a, b, c_in));
                @(posedge clk); #1;
                if (done) begin
                    ndone++;
                    if (prev >= 0) chk("b2b_spacing", cyc - prev, K + 2);
                    prev = cyc;
                    if (q.size() == 0) chk("b2b_queue_empty", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("b2b_result", {ovf, c_out, s}, e);
                    end
                end
            end
            @(negedge clk); start = 1'b0;
            chk("b2b_done_count", ndone, 4);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Exhaustive sweep of two small configurations driven in lockstep
        for (int m = 0; m < 64; m++) begin
            logic f1, f2;
            logic [3:0] e;
            int n;
            @(negedge clk);
            chk("small_ready", {r1, r2}, 2'b11);
            st = 1'b1; ssub = m[5]; sci = m[4]; xa = m[3:2]; xb = m[1:0];
            @(posedge clk); #1; st = 1'b0;
            f1 = d1; f2 = d2; n = 0;
            while (!(f1 && f2) && n < 10) begin
                @(posedge clk); #1;
                f1 = f1 | d1; f2 = f2 | d2; n++;
            end
            e = model2(m[5], m[3:2], m[1:0], m[4]);
            chk($sformatf("n1k2_m%0d", m), {f1, ov1, co1, s1}, {1'b1, e});
            chk($sformatf("n2k1_m%0d", m), {f2, ov2, co2, s2}, {1'b1, e});
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
